// File: rtl/fm_row_streamer.sv
// -----------------------------------------------------------------------------
// fm_row_streamer
//
// Streams one image frame from a 16-bit image SRAM into the accelerator's
// 208-bit feature-map input, one packed row of 26 8-bit pixels per strobe,
// then waits for the accelerator's classification result.
//
// Frame sequence:
//   IDLE/DONE --i_start--> WAIT_RDY --i_acc_ready--> (FETCH -> EMIT) x ROWS
//   --> WAIT_RES (no result captured yet) or DONE (result already captured)
//
// Row timing: 13 SRAM read cycles, 1 read-latency cycle (still in FETCH,
// o_sram_cs low), 1 EMIT cycle carrying the strobe => 15 cycles per row.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   i_start              frame start request, honoured in IDLE/DONE only
//   i_base_addr [AW]     word address of row 0 pixel 0, latched on start
//   o_acc_start          one-cycle accelerator start pulse
//   i_acc_ready          accelerator weight load complete (level)
//   o_sram_cs            SRAM read enable
//   o_sram_addr [AW]     SRAM word address (holds last value when idle)
//   i_sram_rdata [16]    SRAM read data, valid 1 cycle after o_sram_cs
//   o_fm_data [208]      packed row, pixel j at [8j+7:8j]
//   o_fm_data_valid      one-cycle row strobe
//   i_result_data [5]    accelerator classification result
//   i_result_valid       result strobe
//   o_result [5]         captured result
//   o_busy               high in every state except IDLE and DONE
//   o_done               high in DONE
//
// Configuration macro:
//   FM_STREAM_PAD_EN     when defined, an all-zero padding row is emitted
//                        before row 0 and after row ROWS-1 (one EMIT cycle
//                        each, no SRAM access).
// -----------------------------------------------------------------------------
module fm_row_streamer #(
   parameter int ROWS = 26,
   parameter int AW   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [AW-1:0] i_base_addr,
   output logic          o_acc_start,
   input  logic          i_acc_ready,
   output logic          o_sram_cs,
   output logic [AW-1:0] o_sram_addr,
   input  logic [15:0]   i_sram_rdata,
   output logic [207:0]  o_fm_data,
   output logic          o_fm_data_valid,
   input  logic [4:0]    i_result_data,
   input  logic          i_result_valid,
   output logic [4:0]    o_result,
   output logic          o_busy,
   output logic          o_done
);

   localparam logic [3:0]    LAST_WORD = 4'd12;  // word index of the 13th read
   localparam logic [3:0]    LAT_SLOT  = 4'd13;  // read-latency cycle of a row
   localparam logic [AW-1:0] ROW_WORDS = AW'(13);
   localparam logic [7:0]    LAST_ROW  = 8'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_FETCH,
      S_EMIT,
      S_WAIT_RES,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_next;
   state_t          w_end_state;

   logic [3:0]      r_wcnt;        // FETCH cycle index 0..13
   logic [7:0]      r_row;         // data row currently being streamed
   logic [AW-1:0]   r_row_addr;    // base + 13*row
   logic [AW-1:0]   r_addr;
   logic            r_res_flag;
   logic [4:0]      r_result;
   logic [207:0]    r_fm_data;
   logic            r_fm_valid;
   logic            r_acc_start;
   logic [15:0]     r_buf [0:11];  // words 0..11 of the row being assembled
   logic [3:0]      w_buf_idx;
   logic [207:0]    w_row_word;

   logic            w_start_ok;
   logic            w_busy;
   logic            w_last_row;
   logic            w_data_emit;
   logic            w_res_seen;

`ifdef FM_STREAM_PAD_EN
   logic            r_pad_lead;    // current EMIT is the leading zero row
   logic            r_pad_trail;   // current EMIT is the trailing zero row
   assign w_data_emit = (r_state == S_EMIT) && !r_pad_lead && !r_pad_trail;
`else
   assign w_data_emit = (r_state == S_EMIT);
`endif

   assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign w_last_row  = (r_row == LAST_ROW);
   // A result strobe in the very cycle the last row leaves must still count.
   assign w_res_seen  = r_res_flag || i_result_valid;
   assign w_end_state = w_res_seen ? S_DONE : S_WAIT_RES;
   assign w_buf_idx   = r_wcnt - 4'd1;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   // NOTE: w_next gets a default before the case so that no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) w_next = S_WAIT_RDY;
         end
         S_WAIT_RDY: begin
`ifdef FM_STREAM_PAD_EN
            if (i_acc_ready) w_next = S_EMIT;
`else
            if (i_acc_ready) w_next = S_FETCH;
`endif
         end
         S_FETCH: begin
            if (r_wcnt == LAT_SLOT) w_next = S_EMIT;
         end
         S_EMIT: begin
`ifdef FM_STREAM_PAD_EN
            if (r_pad_lead)       w_next = S_FETCH;
            else if (r_pad_trail) w_next = w_end_state;
            else if (w_last_row)  w_next = S_EMIT;
            else                  w_next = S_FETCH;
`else
            w_next = w_last_row ? w_end_state : S_FETCH;
`endif
         end
         S_WAIT_RES: begin
            if (i_result_valid) w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Completed row: words 0..11 from the buffer, word 12 straight off the bus
   // during the latency cycle.
   always_comb begin
      w_row_word = '0;
      for (int k = 0; k < 12; k++) begin
         w_row_word[16*k +: 16] = r_buf[k];
      end
      w_row_word[207:192] = i_sram_rdata;
   end

   // -------------------------------------------------------------------------
   // State and control registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wcnt      <= '0;
         r_row       <= '0;
         r_row_addr  <= '0;
         r_addr      <= '0;
         r_res_flag  <= 1'b0;
         r_result    <= '0;
         r_fm_data   <= '0;
         r_fm_valid  <= 1'b0;
         r_acc_start <= 1'b0;
`ifdef FM_STREAM_PAD_EN
         r_pad_lead  <= 1'b0;
         r_pad_trail <= 1'b0;
`endif
      end else begin
         r_state     <= w_next;
         r_acc_start <= w_start_ok;
         r_fm_valid  <= (w_next == S_EMIT);
         r_wcnt      <= ((r_state == S_FETCH) && (w_next == S_FETCH)) ? r_wcnt + 4'd1 : 4'd0;

         if (w_start_ok) begin
            r_row_addr <= i_base_addr;
            r_row      <= '0;
            r_res_flag <= 1'b0;
         end else if (w_data_emit) begin
            r_row      <= r_row + 8'd1;
            r_row_addr <= r_row_addr + ROW_WORDS;
         end

         if (w_busy && i_result_valid) begin
            r_result   <= i_result_data;
            r_res_flag <= 1'b1;
         end

         // Entering FETCH after a data row already points at the next row.
         if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
            r_addr <= w_data_emit ? r_row_addr + ROW_WORDS : r_row_addr;
         end else if ((r_state == S_FETCH) && (r_wcnt < LAST_WORD)) begin
            r_addr <= r_addr + AW'(1);
         end

         // o_fm_data only changes when a new row is complete, so it stays
         // stable between strobes.
         if ((r_state == S_FETCH) && (w_next == S_EMIT)) begin
            r_fm_data <= w_row_word;
`ifdef FM_STREAM_PAD_EN
         end else if (w_next == S_EMIT) begin
            r_fm_data <= '0;
`endif
         end

`ifdef FM_STREAM_PAD_EN
         r_pad_lead  <= (r_state == S_WAIT_RDY) && (w_next == S_EMIT);
         r_pad_trail <= w_data_emit && w_last_row;
`endif
      end
   end

   // NOTE: the row buffer has no reset; every entry is rewritten before it is
   // read, and leaving it out keeps it a plain register file.
   always_ff @(posedge clk) begin
      if ((r_state == S_FETCH) && (r_wcnt != 4'd0) && (r_wcnt <= LAST_WORD)) begin
         r_buf[w_buf_idx] <= i_sram_rdata;
      end
   end

   assign o_acc_start     = r_acc_start;
   assign o_sram_cs       = (r_state == S_FETCH) && (r_wcnt <= LAST_WORD);
   assign o_sram_addr     = r_addr;
   assign o_fm_data       = r_fm_data;
   assign o_fm_data_valid = r_fm_valid;
   assign o_result        = r_result;
   assign o_busy          = w_busy;
   assign o_done          = (r_state == S_DONE);

endmodule
